// File: rtl/inv_sub_bytes_seq.sv
// Sequential AES inverse SubBytes: LANES shared arithmetic inverse S-boxes, MSB group first.
// Optional completed-block counter enabled by defining INV_SUB_BYTES_COUNT_EN.
module inv_sub_bytes_seq #(
    parameter int unsigned LANES = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] in,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] out
`ifdef INV_SUB_BYTES_COUNT_EN
    ,
    output logic [31:0]  blocks_done
`endif
);

    localparam int unsigned N  = 16 / LANES;
    localparam int unsigned GW = (N > 1) ? $clog2(N) : 1;
    localparam int unsigned LW = 8 * LANES;
    localparam logic [GW-1:0] GrpLast = GW'(N - 1);

    typedef enum logic [1:0] {StIdle, StBusy, StDone} state_e;

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = '0;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    // a^254 == a^-1 for a != 0, and yields 0 for a == 0.
    function automatic logic [7:0] gf_inv(input logic [7:0] a);
        logic [7:0] sq;
        logic [7:0] r;
        sq = a;
        r  = 8'h01;
        for (int i = 1; i < 8; i++) begin
            sq = gf_mul(sq, sq);
            r  = gf_mul(r, sq);
        end
        return r;
    endfunction

    function automatic logic [7:0] inv_sbox(input logic [7:0] b);
        logic [7:0] t;
        t = {b[6:0], b[7]} ^ {b[4:0], b[7:5]} ^ {b[1:0], b[7:2]} ^ 8'h05;
        return gf_inv(t);
    endfunction

    state_e          state_q, state_d;
    logic [GW-1:0]   grp_q, grp_d;
    logic [127:0]    work_q, work_d;
    logic [127:0]    shifted, grp_mask, lane_ext;
    logic [LW-1:0]   lane_in, lane_out;
    logic [6:0]      shamt;

    // Position of the current group within the working register.
    always_comb begin
        shamt    = 7'(LW * (N - 1 - 32'(grp_q)));
        shifted  = work_q >> shamt;
        lane_in  = shifted[LW-1:0];
        grp_mask = '0;
        grp_mask[LW-1:0] = '1;
        lane_ext = '0;
        lane_ext[LW-1:0] = lane_out;
    end

    for (genvar g = 0; g < LANES; g++) begin : g_lane
        assign lane_out[8*g +: 8] = inv_sbox(lane_in[8*g +: 8]);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            grp_q   <= '0;
            work_q  <= '0;
        end else begin
            state_q <= state_d;
            grp_q   <= grp_d;
            work_q  <= work_d;
        end
    end

    always_comb begin
        state_d = state_q;
        grp_d   = grp_q;
        work_d  = work_q;
        unique case (state_q)
            StIdle: begin
                if (in_valid) begin
                    work_d  = in;
                    grp_d   = '0;
                    state_d = StBusy;
                end
            end
            StBusy: begin
                work_d = (work_q & ~(grp_mask << shamt)) | (lane_ext << shamt);
                grp_d  = grp_q + 1'b1;
                if (grp_q == GrpLast) state_d = StDone;
            end
            StDone: begin
                if (out_ready) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        in_ready  = (state_q == StIdle);
        out_valid = (state_q == StDone);
        out       = out_valid ? work_q : '0;
    end

`ifdef INV_SUB_BYTES_COUNT_EN
    logic [31:0] count_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
        end else if (state_q == StDone && out_ready) begin
            count_q <= count_q + 32'd1;
        end
    end

    assign blocks_done = count_q;
`endif

endmodule

// File: tb/tb_inv_sub_bytes_seq.sv
// Bench for inv_sub_bytes_seq: table-based inverse S-box model built from the forward S-box,
// per-cycle handshake comparison, and directed vectors (counter tests with INV_SUB_BYTES_COUNT_EN).
module tb_inv_sub_bytes_seq;

    localparam int unsigned N4 = 4;
    localparam logic [127:0] FipsIn  = 128'h7a9f102789d5f50b2beffd9f3dca4ea7;
    localparam logic [127:0] FipsOut = 128'hbd6e7c3df2b5779e0b61216e8b10b689;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst, in_valid, in_ready, out_valid, out_ready;
    logic [127:0] din, dout;
    logic         iv_x, or_x, ir1, ov1, ir16, ov16;
    logic [127:0] out1, out16;
`ifdef INV_SUB_BYTES_COUNT_EN
    logic [31:0]  blocks_done;
`endif

    int checks = 0;
    int errors = 0;

    logic [7:0]   inv_tbl [256];
    logic [127:0] m_out;
    int           m_busy;
    bit           m_done;
    logic [31:0]  m_count;

    inv_sub_bytes_seq #(.LANES(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in        (din),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out       (dout)
`ifdef INV_SUB_BYTES_COUNT_EN
        ,
        .blocks_done (blocks_done)
`endif
    );

    inv_sub_bytes_seq #(.LANES(1)) dut1 (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (iv_x),
        .in_ready  (ir1),
        .in        (din),
        .out_valid (ov1),
        .out_ready (or_x),
        .out       (out1)
`ifdef INV_SUB_BYTES_COUNT_EN
        ,
        .blocks_done ()
`endif
    );

    inv_sub_bytes_seq #(.LANES(16)) dut16 (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (iv_x),
        .in_ready  (ir16),
        .in        (din),
        .out_valid (ov16),
        .out_ready (or_x),
        .out       (out16)
`ifdef INV_SUB_BYTES_COUNT_EN
        ,
        .blocks_done ()
`endif
    );

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [7:0] clmul_mod(input logic [7:0] a, input logic [7:0] b);
        logic [15:0] p;
        p = '0;
        for (int i = 0; i < 8; i++) if (b[i]) p = p ^ (16'(a) << i);
        for (int i = 15; i >= 8; i--) if (p[i]) p = p ^ (16'h011b << (i - 8));
        return p[7:0];
    endfunction

    function automatic logic [7:0] rotl(input logic [7:0] b, input int n);
        return (b << n) | (b >> (8 - n));
    endfunction

    // Forward S-box from its definition, then inverted as a lookup table.
    task automatic build_tables();
        logic [7:0] inv [256];
        logic [7:0] s;
        inv[0] = 8'h00;
        for (int x = 1; x < 256; x++) begin
            inv[x] = 8'h00;
            for (int y = 1; y < 256; y++)
                if (clmul_mod(8'(x), 8'(y)) == 8'h01) inv[x] = 8'(y);
        end
        for (int x = 0; x < 256; x++) begin
            s = inv[x];
            s = s ^ rotl(s, 1) ^ rotl(s, 2) ^ rotl(s, 3) ^ rotl(s, 4) ^ 8'h63;
            inv_tbl[s] = 8'(x);
        end
    endtask

    function automatic logic [127:0] model_block(input logic [127:0] d);
        logic [127:0] r;
        for (int i = 0; i < 16; i++) r[8*i +: 8] = inv_tbl[d[8*i +: 8]];
        return r;
    endfunction

    // Cycle model of the main instance, compared every cycle.
    initial begin
        m_busy  = 0;
        m_done  = 1'b0;
        m_out   = '0;
        m_count = '0;
        forever begin
            @(posedge clk);
            if (rst) begin
                m_busy  = 0;
                m_done  = 1'b0;
                m_out   = '0;
                m_count = '0;
            end else if (m_busy > 0) begin
                m_busy--;
                if (m_busy == 0) m_done = 1'b1;
            end else if (m_done) begin
                if (out_ready) begin
                    m_done  = 1'b0;
                    m_count = m_count + 32'd1;
                end
            end else if (in_valid) begin
                m_busy = N4;
                m_out  = model_block(din);
            end
            #1;
            check("cmp_in_ready", in_ready, (m_busy == 0 && !m_done));
            check("cmp_out_valid", out_valid, m_done);
            if (m_done) check("cmp_out", dout, m_out);
`ifdef INV_SUB_BYTES_COUNT_EN
            check("cmp_blocks_done", blocks_done, m_count);
`endif
        end
    end

    task automatic accept(input logic [127:0] d);
        int guard = 0;
        @(negedge clk);
        din      = d;
        in_valid = 1'b1;
        while (!in_ready && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        if (!in_ready) check("accept_timeout", in_ready, 1'b1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        din      = ~d;
    endtask

    task automatic wait_done(output int lat);
        lat = 0;
        while (!out_valid && lat < 100) begin
            @(posedge clk);
            #1;
            lat++;
        end
        check("done_timeout", out_valid, 1'b1);
    endtask

    task automatic consume();
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        check("in_ready_after_consume", in_ready, 1'b1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int           lat, lat1, lat16;
        logic [127:0] d, e;
        logic [7:0]   sb_pos [5];
        logic [7:0]   sb_val [5];
        logic [7:0]   sb_exp [5];

        sb_pos = '{8'd15, 8'd9, 8'd6, 8'd3, 8'd0};
        sb_val = '{8'h63, 8'h7c, 8'hff, 8'h16, 8'h00};
        sb_exp = '{8'h00, 8'h01, 8'h7d, 8'hff, 8'h52};

        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; iv_x = 1'b0; or_x = 1'b0; din = '0;
        build_tables();
        check("model_63", inv_tbl[8'h63], 8'h00);
        check("model_7c", inv_tbl[8'h7c], 8'h01);
        check("model_ff", inv_tbl[8'hff], 8'h7d);
        check("model_16", inv_tbl[8'h16], 8'hff);
        check("model_00", inv_tbl[8'h00], 8'h52);

        repeat (3) @(negedge clk);
        check("reset_in_ready", in_ready, 1'b1);
        check("reset_out_valid", out_valid, 1'b0);
        check("reset_out", dout, 128'h0);
`ifdef INV_SUB_BYTES_COUNT_EN
        check("reset_blocks_done", blocks_done, 32'h0);
`endif
        rst = 1'b0;
        repeat (2) @(negedge clk);
        check("idle_in_ready", in_ready, 1'b1);
        check("idle_out_valid", out_valid, 1'b0);

        // Reset sampled on E2 while busy.
        accept(FipsIn);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("midbusy_out_valid", out_valid, 1'b0);
        check("midbusy_in_ready", in_ready, 1'b1);
        check("midbusy_out", dout, 128'h0);
`ifdef INV_SUB_BYTES_COUNT_EN
        check("midbusy_blocks_done", blocks_done, 32'h0);
`endif
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 5; i++) begin
            d = '0;
            d[8*sb_pos[i] +: 8] = sb_val[i];
            e = {16{8'h52}};
            e[8*sb_pos[i] +: 8] = sb_exp[i];
            accept(d);
            wait_done(lat);
            check("single_byte_latency", lat, N4);
            check("single_byte_out", dout, e);
            consume();
        end

        accept(FipsIn);
        wait_done(lat);
        check("fips_latency_l4", lat, N4);
        check("fips_out_l4", dout, FipsOut);

        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            din      = 128'($urandom) ^ {$urandom, $urandom, $urandom, $urandom};
            in_valid = c[0];
            #1;
            check("bp_out_stable", dout, FipsOut);
            check("bp_in_ready", in_ready, 1'b0);
            check("bp_out_valid", out_valid, 1'b1);
        end
        @(negedge clk);
        in_valid = 1'b0;
        consume();

        // LANES=1 and LANES=16 latency on the FIPS vector.
        @(negedge clk);
        din  = FipsIn;
        iv_x = 1'b1;
        @(posedge clk);
        #1;
        iv_x = 1'b0;
        din  = ~FipsIn;
        lat1  = 0;
        lat16 = 0;
        for (int c = 1; c <= 40; c++) begin
            @(posedge clk);
            #1;
            if (ov1 && lat1 == 0) lat1 = c;
            if (ov16 && lat16 == 0) lat16 = c;
        end
        check("fips_latency_l1", lat1, 16);
        check("fips_latency_l16", lat16, 1);
        check("fips_out_l1", out1, FipsOut);
        check("fips_out_l16", out16, FipsOut);
        @(negedge clk);
        or_x = 1'b1;
        @(posedge clk);
        #1;
        or_x = 1'b0;
        check("l1_in_ready_after_consume", ir1, 1'b1);
        check("l16_in_ready_after_consume", ir16, 1'b1);

`ifdef INV_SUB_BYTES_COUNT_EN
        @(negedge clk);
        dut.count_q = 32'hffff_fffe;
        m_count     = 32'hffff_fffe;
        accept(FipsIn);
        wait_done(lat);
        consume();
        check("wrap_first", blocks_done, 32'hffff_ffff);
        accept(FipsIn);
        wait_done(lat);
        consume();
        check("wrap_second", blocks_done, 32'h0000_0000);
`endif

        repeat (3) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/inv_sub_bytes_seq.md
# inv_sub_bytes_seq

Sequential AES inverse SubBytes stage for the decryption datapath. It sits directly downstream of the inverse ShiftRows stage and takes that stage's 128-bit state over a valid/ready handshake. It applies the inverse S-box to all 16 bytes using `LANES` shared inverse S-box units, processing `LANES` bytes per cycle. It presents the result, held, to the next stage (AddRoundKey).

## Interface
- `LANES`, default 4: inverse S-box units instantiated; legal values 1, 2, 4, 8, 16; groups per block N = 16/LANES.
- `clk` in 1: sole clock; all state updates on rising edge.
- `rst` in 1: synchronous, active-high reset.
- `in_valid` in 1: `in` holds a state to process.
- `in_ready` out 1: block can accept a state this cycle.
- `in` in 128: input state, byte 15 in [127:120] down to byte 0 in [7:0].
- `out_valid` out 1: `out` holds a completed state.
- `out_ready` in 1: downstream consumes `out` this cycle.
- `out` out 128: inverse-substituted state, same byte ordering as `in`.
- `blocks_done` out 32: only with `INV_SUB_BYTES_COUNT_EN`, see Configuration.

## Operation
- Inverse S-box per byte is arithmetic, with no 256-entry table:
  - Apply the inverse affine transform: b' = rotl1(b) ^ rotl3(b) ^ rotl6(b) ^ 0x05.
  - Then take the multiplicative inverse in GF(2^8) mod x^8+x^4+x^3+x+1, with 0 mapped to 0.
- FSM states: IDLE, BUSY, DONE.
- IDLE:
  - `in_ready`=1, `out_valid`=0.
  - On `in_valid`: capture `in` into the working register, clear group counter `grp`, go to BUSY.
- BUSY:
  - `in_ready`=0, `out_valid`=0.
  - Each cycle, replace bytes [16-LANES*grp-1 : 16-LANES*(grp+1)] of the working register with their inverse S-box values. Processing is MSB group first.
  - Increment `grp`. When `grp`==N-1 this cycle, go to DONE.
- DONE:
  - `out_valid`=1; `out` = working register, held stable.
  - `in_ready`=0.
  - On `out_ready`: go to IDLE.
- `in` is sampled only on the accepting edge. Later changes on `in` do not affect the block in flight.
- `in_ready` is a registered-state decode only. It has no combinational path from `out_ready`.
- Reset in any state, including mid-BUSY:
  - Next state IDLE; `grp`=0; working register cleared to 0.
  - `out_valid`=0, `in_ready`=1, `out`=0.
  - The in-flight block is discarded and not counted.

## Timing
- Reset values: `in_ready`=1, `out_valid`=0, `out`=0, `blocks_done`=0.
- Accepting edge E0 (IDLE, `in_valid`=1). Groups are processed on edges E1..EN.
- `out_valid` is high from EN onward. Latency is N cycles from acceptance to `out_valid`.
- Consuming edge (DONE, `out_ready`=1) gives IDLE next cycle, so `in_ready`=1 one cycle after consumption.
- Minimum spacing between accepted blocks is N+2 cycles: 6 for LANES=4, 3 for LANES=16.
- `out_ready` high while not in DONE is ignored. `in_valid` high while not in IDLE is ignored; the upstream must hold it.

## Configuration
- `INV_SUB_BYTES_COUNT_EN` defined:
  - Adds port `blocks_done` (32-bit), reset to 0.
  - Increments by 1 on each consuming edge (DONE & `out_ready`) and wraps 0xFFFFFFFF to 0.
- Undefined: no `blocks_done` port and no counter logic. All other behaviour is identical.

## Test plan
- Reset then idle:
  - `in_ready`=1, `out_valid`=0, `out`=0.
  - With COUNT_EN, `blocks_done`=0.
- Single bytes, with the rest of the state 0x00:
  - `in` bytes 0x63, 0x7c, 0xff, 0x16, 0x00 give `out` bytes 0x00, 0x01, 0x7d, 0xff, 0x52 respectively.
  - Remaining bytes read 0x52.
- FIPS-197 vector:
  - `in`=7a9f102789d5f50b2beffd9f3dca4ea7 gives `out`=bd6e7c3df2b5779e0b61216e8b10b689.
  - `out_valid` is high exactly N edges after acceptance; check for LANES=1, 4 and 16.
- Backpressure:
  - Hold `out_ready`=0 for 10 cycles in DONE: `out` stable and `in_ready`=0 throughout, while `in` toggles.
  - Raise `out_ready`: `in_ready`=1 on the next cycle.
- Reset mid-BUSY:
  - Assert `rst` on edge E2 with LANES=4: next cycle `out_valid`=0, `in_ready`=1, `out`=0.
  - `blocks_done` is unchanged.
- Counter wrap (COUNT_EN):
  - Force the counter to 0xFFFFFFFE and consume 2 blocks: reads 0xFFFFFFFF, then 0x00000000.
